// File: rtl/alu_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_pkg
// Purpose  : Shared op-type layout, M-extension funct3 codes and FSM states.
// Revision : 1.0
// ============================================================================
`ifndef RS_TYPE_WIDTH
`define RS_TYPE_WIDTH 7
`endif

package alu_muldiv_pkg;
   localparam int c_type_w   = `RS_TYPE_WIDTH;
   localparam int c_bit_mext = 6;
   localparam int c_bit_jb   = 5;
   localparam int c_bit_imm  = 4;
   localparam int c_bit_alt  = 3;

   localparam logic [2:0] c_f3_mul    = 3'd0;
   localparam logic [2:0] c_f3_mulh   = 3'd1;
   localparam logic [2:0] c_f3_mulhsu = 3'd2;
   localparam logic [2:0] c_f3_mulhu  = 3'd3;
   localparam logic [2:0] c_f3_div    = 3'd4;
   localparam logic [2:0] c_f3_divu   = 3'd5;
   localparam logic [2:0] c_f3_rem    = 3'd6;
   localparam logic [2:0] c_f3_remu   = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_e;
endpackage

`default_nettype wire

// File: rtl/alu_muldiv_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter
// Purpose  : Radix-2 restoring divider on unsigned magnitudes, XLEN steps.
// Revision : 1.0
// ============================================================================
module div_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_en,
   input  logic            i_kill,
   input  logic            i_start,
   input  logic [XLEN-1:0] i_dividend,
   input  logic [XLEN-1:0] i_divisor,
   output logic            o_done,
   output logic [XLEN-1:0] o_quot,
   output logic [XLEN-1:0] o_rem
);
   localparam int c_cnt_w = $clog2(XLEN + 1);

   logic               r_run;
   logic [c_cnt_w-1:0] r_cnt;
   logic [XLEN-1:0]    r_q;
   logic [XLEN-1:0]    r_r;
   logic [XLEN-1:0]    r_d;
   logic [XLEN:0]      w_sh;
   logic [XLEN:0]      w_diff;
   logic               w_ge;
   logic [XLEN-1:0]    w_q_nxt;
   logic [XLEN-1:0]    w_r_nxt;

   // Bit XLEN of the difference is the borrow: partial remainder < divisor.
   assign w_sh    = {r_r, r_q[XLEN-1]};
   assign w_diff  = w_sh - {1'b0, r_d};
   assign w_ge    = ~w_diff[XLEN];
   assign w_r_nxt = w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0];
   assign w_q_nxt = {r_q[XLEN-2:0], w_ge};

   // The final step's outputs are consumed combinationally by the caller.
   assign o_done = r_run && (r_cnt == c_cnt_w'(1));
   assign o_quot = w_q_nxt;
   assign o_rem  = w_r_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run <= 1'b0;
         r_cnt <= '0;
         r_q   <= '0;
         r_r   <= '0;
         r_d   <= '0;
      end else if (i_en) begin
         if (i_kill) begin
            r_run <= 1'b0;
         end else if (i_start) begin
            r_run <= 1'b1;
            r_cnt <= c_cnt_w'(XLEN);
            r_q   <= i_dividend;
            r_r   <= '0;
            r_d   <= i_divisor;
         end else if (r_run) begin
            r_q   <= w_q_nxt;
            r_r   <= w_r_nxt;
            r_cnt <= r_cnt - c_cnt_w'(1);
            if (r_cnt == c_cnt_w'(1)) r_run <= 1'b0;
         end
      end
   end
endmodule

`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv
// Purpose  : Integer/branch/JALR ALU with fixed-latency MUL and iterative DIV.
//            Define ALU_DIV_EARLY_OUT_EN for 1-cycle trivial divides.
// Revision : 1.0
// ============================================================================
module alu_muldiv
   import alu_muldiv_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ROB_ID_W = 32,
   parameter int MUL_LAT  = 3
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                rdy_in,
   input  logic                flush,
   input  logic                en,
   input  logic [ROB_ID_W-1:0] rob_id_in,
   input  logic [XLEN-1:0]     data_j,
   input  logic [XLEN-1:0]     data_k,
   input  logic [XLEN-1:0]     imm,
   input  logic [c_type_w-1:0] type_in,
   output logic                busy,
   output logic                rdy,
   output logic [ROB_ID_W-1:0] rob_id_out,
   output logic [XLEN-1:0]     result,
   output logic                set_jump_addr
);
   localparam int              c_sh_w  = $clog2(XLEN);
   localparam int              c_cnt_w = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [XLEN-1:0] c_xmin  = {1'b1, {(XLEN-1){1'b0}}};

   state_e              r_state, w_state_nxt;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [XLEN-1:0]     r_ma, r_mb, r_dvd, r_result;
   logic [2:0]          r_f3;
   logic [ROB_ID_W-1:0] r_tag, r_tag_out;
   logic                r_neg_q, r_neg_r, r_divz, r_is_rem, r_rdy, r_jump;

   logic                w_accept, w_is_m, w_is_div, w_is_jalr, w_br;
   logic [2:0]          w_f3, w_mf3;
   logic [XLEN-1:0]     w_opb, w_alu, w_nonm_res, w_mul_a, w_mul_b, w_mul_res;
   logic [c_sh_w-1:0]   w_shamt;
   logic                w_a_sgn, w_b_sgn;
   logic [2*XLEN-1:0]   w_a_ext, w_b_ext, w_prod;
   logic                w_dsgn, w_j_neg, w_k_neg, w_k_zero, w_early, w_div_start, w_div_done;
   logic [XLEN-1:0]     w_j_mag, w_k_mag, w_dq, w_dr, w_div_res, w_early_res;
   logic                w_done, w_done_jmp;
   logic [XLEN-1:0]     w_done_res;
   logic [ROB_ID_W-1:0] w_done_tag;

   assign busy          = (r_state != S_IDLE);
   assign rdy           = r_rdy;
   assign rob_id_out    = r_tag_out;
   assign result        = r_result;
   assign set_jump_addr = r_jump;

   assign w_accept  = en && !busy && rdy_in;
   assign w_f3      = type_in[2:0];
   assign w_is_m    = type_in[c_bit_mext];
   assign w_is_div  = w_is_m && w_f3[2];
   assign w_is_jalr = !w_is_m && type_in[c_bit_jb] && type_in[c_bit_imm];

   assign w_opb   = type_in[c_bit_imm] ? imm : data_k;
   assign w_shamt = w_opb[c_sh_w-1:0];

   always_comb begin
      w_alu = '0;
      case (w_f3)
         3'd0: w_alu = type_in[c_bit_alt] ? data_j - w_opb : data_j + w_opb;
         3'd1: w_alu = data_j << w_shamt;
         3'd2: w_alu = {{(XLEN-1){1'b0}}, $signed(data_j) < $signed(w_opb)};
         3'd3: w_alu = {{(XLEN-1){1'b0}}, data_j < w_opb};
         3'd4: w_alu = data_j ^ w_opb;
         3'd5: w_alu = type_in[c_bit_alt] ? $signed(data_j) >>> w_shamt : data_j >> w_shamt;
         3'd6: w_alu = data_j | w_opb;
         default: w_alu = data_j & w_opb;
      endcase
   end

   always_comb begin
      w_br = 1'b0;
      case (w_f3)
         3'd0: w_br = (data_j == data_k);
         3'd1: w_br = (data_j != data_k);
         3'd4: w_br = ($signed(data_j) <  $signed(data_k));
         3'd5: w_br = ($signed(data_j) >= $signed(data_k));
         3'd6: w_br = (data_j <  data_k);
         3'd7: w_br = (data_j >= data_k);
         default: w_br = 1'b0;
      endcase
   end

   assign w_nonm_res = !type_in[c_bit_jb]  ? w_alu :
                       type_in[c_bit_imm] ? data_j + imm : {{(XLEN-1){1'b0}}, w_br};

   // Live inputs feed the multiplier in IDLE so MUL_LAT==1 needs no extra state.
   assign w_mul_a   = (r_state == S_MUL) ? r_ma : data_j;
   assign w_mul_b   = (r_state == S_MUL) ? r_mb : data_k;
   assign w_mf3     = (r_state == S_MUL) ? r_f3 : w_f3;
   assign w_a_sgn   = (w_mf3 != c_f3_mulhu);
   assign w_b_sgn   = (w_mf3 == c_f3_mul) || (w_mf3 == c_f3_mulh);
   assign w_a_ext   = {{XLEN{w_a_sgn & w_mul_a[XLEN-1]}}, w_mul_a};
   assign w_b_ext   = {{XLEN{w_b_sgn & w_mul_b[XLEN-1]}}, w_mul_b};
   assign w_prod    = w_a_ext * w_b_ext;
   assign w_mul_res = (w_mf3 == c_f3_mul) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

   assign w_dsgn   = (w_f3 == c_f3_div) || (w_f3 == c_f3_rem);
   assign w_j_neg  = w_dsgn && data_j[XLEN-1];
   assign w_k_neg  = w_dsgn && data_k[XLEN-1];
   assign w_j_mag  = w_j_neg ? -data_j : data_j;
   assign w_k_mag  = w_k_neg ? -data_k : data_k;
   assign w_k_zero = (data_k == '0);

`ifdef ALU_DIV_EARLY_OUT_EN
   logic w_ovf, w_small;
   assign w_ovf       = w_dsgn && (data_j == c_xmin) && (&data_k);
   assign w_small     = (w_j_mag < w_k_mag);
   assign w_early     = w_k_zero || w_ovf || w_small;
   assign w_early_res = w_f3[1] ? (w_ovf ? '0 : data_j)
                                : (w_k_zero ? '1 : (w_ovf ? c_xmin : '0));
`else
   assign w_early     = 1'b0;
   assign w_early_res = '0;
`endif

   assign w_div_res = r_divz   ? (r_is_rem ? r_dvd : '1) :
                      r_is_rem ? (r_neg_r ? -w_dr : w_dr) : (r_neg_q ? -w_dq : w_dq);
   assign w_div_start = (r_state == S_IDLE) && (w_state_nxt == S_DIV) && !flush;
   assign w_done_tag  = (r_state == S_IDLE) ? rob_id_in : r_tag;

   div_iter #(.XLEN(XLEN)) u_div (
      .clk       (clk_in),
      .rst       (rst_in),
      .i_en      (rdy_in),
      .i_kill    (flush),
      .i_start   (w_div_start),
      .i_dividend(w_j_mag),
      .i_divisor (w_k_mag),
      .o_done    (w_div_done),
      .o_quot    (w_dq),
      .o_rem     (w_dr)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      w_done_res  = '0;
      w_done_jmp  = 1'b0;
      case (r_state)
         S_IDLE: if (w_accept) begin
            if (!w_is_m) begin
               w_done = 1'b1; w_done_res = w_nonm_res; w_done_jmp = w_is_jalr;
            end else if (w_is_div) begin
               if (w_early) begin w_done = 1'b1; w_done_res = w_early_res; end
               else         w_state_nxt = S_DIV;
            end else if (MUL_LAT == 1) begin
               w_done = 1'b1; w_done_res = w_mul_res;
            end else begin
               w_state_nxt = S_MUL;
            end
         end
         S_MUL: if (r_cnt == c_cnt_w'(1)) begin
            w_done = 1'b1; w_done_res = w_mul_res; w_state_nxt = S_IDLE;
         end
         S_DIV: if (w_div_done) begin
            w_done = 1'b1; w_done_res = w_div_res; w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)      r_state <= S_IDLE;
      else if (rdy_in) r_state <= flush ? S_IDLE : w_state_nxt;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_rdy <= 1'b0; r_tag_out <= '0; r_result <= '0; r_jump <= 1'b0;
      end else if (rdy_in) begin
         if (flush) begin
            r_rdy <= 1'b0; r_tag_out <= '0; r_result <= '0; r_jump <= 1'b0;
         end else begin
            r_rdy <= w_done;
            if (w_done) begin
               r_tag_out <= w_done_tag; r_result <= w_done_res; r_jump <= w_done_jmp;
            end
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_cnt <= '0; r_ma <= '0; r_mb <= '0; r_f3 <= '0; r_tag <= '0; r_dvd <= '0;
         r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_divz <= 1'b0; r_is_rem <= 1'b0;
      end else if (rdy_in) begin
         if (w_accept && w_is_m) begin
            r_cnt    <= c_cnt_w'(MUL_LAT - 1);
            r_ma     <= data_j;
            r_mb     <= data_k;
            r_f3     <= w_f3;
            r_tag    <= rob_id_in;
            r_dvd    <= data_j;
            r_neg_q  <= w_j_neg ^ w_k_neg;
            r_neg_r  <= w_j_neg;
            r_divz   <= w_k_zero;
            r_is_rem <= w_f3[1];
         end else if (r_state == S_MUL) begin
            r_cnt <= r_cnt - c_cnt_w'(1);
         end
      end
   end
endmodule

`default_nettype wire
